// File: rtl/hex_entry_if.sv
// Keypad-entry bus: input strobes toward the entry controller, committed value and echo back.
// Parameter DIGITS must match the controller it connects to.
interface hex_entry_if #(
  parameter int unsigned DIGITS = 4
) ();
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic          key_pulse;
  logic [3:0]    key_value;
  logic          clr_pulse;
  logic          bksp_pulse;
  logic          enter_pulse;
  logic          out_ready;
  logic          out_valid;
  logic [BW-1:0] out_value;
  logic [BW-1:0] disp_value;
  logic [CW-1:0] digit_count;
  logic          key_reject;
  logic          timeout_pulse;

  // Driver of keypad strobes and consumer of committed values.
  modport master (
    output key_pulse, key_value, clr_pulse, bksp_pulse, enter_pulse, out_ready,
    input  out_valid, out_value, disp_value, digit_count, key_reject, timeout_pulse
  );

  // Entry controller side.
  modport slave (
    input  key_pulse, key_value, clr_pulse, bksp_pulse, enter_pulse, out_ready,
    output out_valid, out_value, disp_value, digit_count, key_reject, timeout_pulse
  );
endinterface

// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl: collects keypad digit strobes into a DIGITS-nibble hex entry with
// backspace/clear/enter, and hands committed values downstream over valid/ready.
// Optional feature macro: ENTRY_TIMEOUT_EN (inactivity auto-clear after TIMEOUT_CYC cycles).
module hex_entry_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  hex_entry_if.slave  bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  // Elaboration-time parameter sanity.
  if (DIGITS < 1) begin : g_bad_digits
    $error("hex_entry_ctrl: DIGITS must be >= 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("hex_entry_ctrl: TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [BW-1:0] r_out_value;
  logic          r_key_reject;
  logic          r_timeout_pulse;

  state_t        w_state_next;
  logic [BW-1:0] w_buf_next;
  logic [CW-1:0] w_count_next;
  logic          w_out_valid_next;
  logic [BW-1:0] w_out_value_next;
  logic          w_key_reject_next;
  logic          w_timeout_next;
  logic          w_key_acc;
  logic          w_bksp_acc;
  logic          w_any_strobe;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Last idle count before the auto-clear edge: the clear lands TIMEOUT_CYC-1 cycles after activity.
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 2);

  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_next;
`endif

  // Next-state, buffer and output decode; priority clr > enter > bksp > key.
  always_comb begin
    w_state_next      = r_state;
    w_buf_next        = r_buf;
    w_count_next      = r_count;
    w_out_valid_next  = r_out_valid;
    w_out_value_next  = r_out_value;
    w_key_reject_next = bus.key_pulse;
    w_timeout_next    = 1'b0;
    w_key_acc         = 1'b0;
    w_bksp_acc        = 1'b0;
    w_any_strobe      = bus.clr_pulse | bus.enter_pulse | bus.bksp_pulse | bus.key_pulse;

    case (r_state)
      ST_HOLD: begin
        // Pending commit is protected: only the downstream handshake leaves HOLD.
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_next = 1'b0;
          w_buf_next       = '0;
          w_count_next     = '0;
          w_state_next     = ST_EMPTY;
        end
      end
      default: begin
        if (bus.clr_pulse) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_state_next = ST_EMPTY;
        end else if (bus.enter_pulse) begin
          if (r_state != ST_EMPTY) begin
            w_out_value_next = r_buf;
            w_out_valid_next = 1'b1;
            w_state_next     = ST_HOLD;
          end
        end else if (bus.bksp_pulse) begin
          if (r_state != ST_EMPTY) begin
            w_bksp_acc   = 1'b1;
            w_buf_next   = r_buf >> 4;
            w_count_next = r_count - CW'(1);
            w_state_next = (r_count == CW'(1)) ? ST_EMPTY : ST_ENTRY;
          end
        end else if (bus.key_pulse) begin
          if (r_state != ST_FULL) begin
            w_key_acc         = 1'b1;
            w_key_reject_next = 1'b0;
            w_buf_next        = (r_buf << 4) | BW'(bus.key_value);
            w_count_next      = r_count + CW'(1);
            w_state_next      = (r_count + CW'(1) == CW'(DIGITS)) ? ST_FULL : ST_ENTRY;
          end
        end
      end
    endcase

`ifdef ENTRY_TIMEOUT_EN
    // Idle counter runs in ENTRY/FULL; any accepted edit or state change restarts it.
    w_idle_next = '0;
    if ((r_state == ST_ENTRY || r_state == ST_FULL) && (w_state_next == r_state) &&
        !w_key_acc && !w_bksp_acc) begin
      w_idle_next = (r_idle < IDLE_LAST) ? r_idle + IW'(1) : r_idle;
    end
    // Any strobe this cycle takes precedence over the auto-clear.
    if ((r_state == ST_ENTRY || r_state == ST_FULL) && !w_any_strobe &&
        (r_idle == IDLE_LAST)) begin
      w_buf_next     = '0;
      w_count_next   = '0;
      w_state_next   = ST_EMPTY;
      w_idle_next    = '0;
      w_timeout_next = 1'b1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_EMPTY;
      r_buf           <= '0;
      r_count         <= '0;
      r_out_valid     <= 1'b0;
      r_out_value     <= '0;
      r_key_reject    <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_buf           <= w_buf_next;
      r_count         <= w_count_next;
      r_out_valid     <= w_out_valid_next;
      r_out_value     <= w_out_value_next;
      r_key_reject    <= w_key_reject_next;
      r_timeout_pulse <= w_timeout_next;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  // Inactivity counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_next;
    end
  end
`endif

  assign bus.out_valid     = r_out_valid;
  assign bus.out_value     = r_out_value;
  assign bus.disp_value    = r_buf;
  assign bus.digit_count   = r_count;
  assign bus.key_reject    = r_key_reject;
  assign bus.timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed self-checking bench for hex_entry_ctrl (DIGITS=4, TIMEOUT_CYC=16).
module tb_hex_entry_ctrl;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  hex_entry_if #(.DIGITS(4)) bus ();

  hex_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] v);
    bus.key_pulse = 1'b1;
    bus.key_value = v;
    tick();
    bus.key_pulse = 1'b0;
  endtask

  task automatic bksp();
    bus.bksp_pulse = 1'b1;
    tick();
    bus.bksp_pulse = 1'b0;
  endtask

  task automatic enter();
    bus.enter_pulse = 1'b1;
    tick();
    bus.enter_pulse = 1'b0;
  endtask

  task automatic clr();
    bus.clr_pulse = 1'b1;
    tick();
    bus.clr_pulse = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n         = 1'b0;
    bus.key_pulse   = 1'b0;
    bus.key_value   = 4'h0;
    bus.clr_pulse   = 1'b0;
    bus.bksp_pulse  = 1'b0;
    bus.enter_pulse = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_value", 32'(bus.out_value), 32'h0);
    chk("rst_disp", 32'(bus.disp_value), 32'h0);
    chk("rst_count", 32'(bus.digit_count), 32'h0);
    chk("rst_key_reject", 32'(bus.key_reject), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_pulse), 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: 1,2,A,F then enter with ready high
    bus.out_ready = 1'b1;
    press(4'h1); chk("t1_disp1", 32'(bus.disp_value), 32'h1);
    press(4'h2); chk("t1_disp2", 32'(bus.disp_value), 32'h12);
    press(4'hA); chk("t1_disp3", 32'(bus.disp_value), 32'h12A);
    press(4'hF); chk("t1_disp4", 32'(bus.disp_value), 32'h12AF);
    chk("t1_count4", 32'(bus.digit_count), 32'h4);
    enter();
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_value", 32'(bus.out_value), 32'h12AF);
    chk("t1_echo_count", 32'(bus.digit_count), 32'h4);
    tick();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'h0);
    chk("t1_count0", 32'(bus.digit_count), 32'h0);
    chk("t1_disp0", 32'(bus.disp_value), 32'h0);
    chk("t1_value_kept", 32'(bus.out_value), 32'h12AF);

    // 2: key into FULL rejected, then backspace
    bus.out_ready = 1'b0;
    press(4'h1); press(4'h2); press(4'hA); press(4'hF);
    chk("t2_no_reject", 32'(bus.key_reject), 32'h0);
    press(4'h7);
    chk("t2_reject", 32'(bus.key_reject), 32'h1);
    chk("t2_disp_kept", 32'(bus.disp_value), 32'h12AF);
    tick();
    chk("t2_reject_pulse", 32'(bus.key_reject), 32'h0);
    bksp();
    chk("t2_bksp_disp", 32'(bus.disp_value), 32'h012A);
    chk("t2_bksp_count", 32'(bus.digit_count), 32'h3);

    // 3: HOLD with back-pressure, clr+key ignored
    enter();
    chk("t3_valid", 32'(bus.out_valid), 32'h1);
    chk("t3_value", 32'(bus.out_value), 32'h012A);
    bus.clr_pulse = 1'b1;
    bus.key_pulse = 1'b1;
    bus.key_value = 4'h9;
    tick();
    bus.clr_pulse = 1'b0;
    bus.key_pulse = 1'b0;
    chk("t3_hold_reject", 32'(bus.key_reject), 32'h1);
    chk("t3_hold_valid", 32'(bus.out_valid), 32'h1);
    chk("t3_hold_count", 32'(bus.digit_count), 32'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_loop_valid", 32'(bus.out_valid), 32'h1);
      chk("t3_hold_loop_value", 32'(bus.out_value), 32'h012A);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_xfer_valid", 32'(bus.out_valid), 32'h0);
    chk("t3_xfer_count", 32'(bus.digit_count), 32'h0);
    chk("t3_xfer_disp", 32'(bus.disp_value), 32'h0);
    chk("t3_xfer_value", 32'(bus.out_value), 32'h012A);
    tick();
    chk("t3_single_xfer", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;
    press(4'h4);
    chk("t3_empty_key", 32'(bus.disp_value), 32'h4);

    // 4: clr+enter+key together, enter/bksp in EMPTY
    bus.clr_pulse   = 1'b1;
    bus.enter_pulse = 1'b1;
    bus.key_pulse   = 1'b1;
    bus.key_value   = 4'h8;
    tick();
    bus.clr_pulse   = 1'b0;
    bus.enter_pulse = 1'b0;
    bus.key_pulse   = 1'b0;
    chk("t4_disp", 32'(bus.disp_value), 32'h0);
    chk("t4_count", 32'(bus.digit_count), 32'h0);
    chk("t4_no_valid", 32'(bus.out_valid), 32'h0);
    chk("t4_reject", 32'(bus.key_reject), 32'h1);
    enter();
    chk("t4_empty_enter", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t4_empty_enter2", 32'(bus.out_valid), 32'h0);
    press(4'h9);
    bksp();
    chk("t4_bksp_to_empty", 32'(bus.digit_count), 32'h0);
    bksp();
    chk("t4_bksp_empty_count", 32'(bus.digit_count), 32'h0);
    chk("t4_bksp_empty_disp", 32'(bus.disp_value), 32'h0);

    // 5: inactivity timeout
`ifdef ENTRY_TIMEOUT_EN
    press(4'h5);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("t5_no_timeout", 32'(bus.timeout_pulse), 32'h0);
    end
    chk("t5_count_before", 32'(bus.digit_count), 32'h1);
    tick();
    chk("t5_timeout", 32'(bus.timeout_pulse), 32'h1);
    chk("t5_count_cleared", 32'(bus.digit_count), 32'h0);
    chk("t5_disp_cleared", 32'(bus.disp_value), 32'h0);
    tick();
    chk("t5_timeout_pulse", 32'(bus.timeout_pulse), 32'h0);
    for (int k = 0; k < 4; k++) begin
      press(4'(k + 5));
      for (int i = 0; i < 9; i++) begin
        tick();
        chk("t5_keepalive", 32'(bus.timeout_pulse), 32'h0);
      end
    end
    chk("t5_keepalive_disp", 32'(bus.disp_value), 32'h5678);
    clr();
`else
    press(4'h5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_timeout", 32'(bus.timeout_pulse), 32'h0);
    end
    chk("t5_count_kept", 32'(bus.digit_count), 32'h1);
    clr();
`endif

    // 6: asynchronous reset during HOLD
    press(4'h1);
    press(4'h2);
    enter();
    chk("t6_hold", 32'(bus.out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_async_disp", 32'(bus.disp_value), 32'h0);
    chk("t6_async_count", 32'(bus.digit_count), 32'h0);
    chk("t6_async_value", 32'(bus.out_value), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_after_reset", 32'(bus.out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
